// File: rtl/activation_pkg.sv
// Shared types and constants for the activation pipeline.
package activation_pkg;

   typedef enum logic [1:0] {
      ACT_SIGMOID = 2'd0,
      ACT_TANH    = 2'd1,
      ACT_RELU    = 2'd2,
      ACT_BYPASS  = 2'd3
   } act_mode_e;

   // One LUT step is 2^-4 in input units.
   localparam int unsigned LUT_STEP_SHIFT = 4;

   // Fixed-point 1.0 for a given number of fractional bits.
   function automatic int unsigned act_one(input int unsigned frac_w);
      return 32'd1 << frac_w;
   endfunction

   // First magnitude past the end of the LUT; anything at or above it saturates.
   function automatic int unsigned act_sat(input int unsigned frac_w, input int unsigned lut_aw);
      return 32'd1 << (lut_aw + frac_w - LUT_STEP_SHIFT);
   endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Registered ROM holding the positive half of the sigmoid, LUT[i] = round(ONE/(1+e^(-i/16))).
module sigmoid_lut
   import activation_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int LUT_AW = 7
) (
   input  logic              clk,
   input  logic              en,
   input  logic [LUT_AW-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam int DEPTH = 1 << LUT_AW;

   // Table entry evaluated at elaboration; rounding is to nearest.
   function automatic logic [DATA_W-1:0] lut_entry(input int i);
      real x;
      real s;
      x = real'(i) / real'(32'd1 << LUT_STEP_SHIFT);
      s = real'(act_one(FRAC_W)) / (1.0 + $exp(-x));
      return DATA_W'($rtoi(s + 0.5));
   endfunction

   logic [DATA_W-1:0] rom [DEPTH];
   logic [DATA_W-1:0] data_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom[gi] = lut_entry(gi);
   end

   // Synchronous read; holds its output whenever the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (en) data_q <= rom[addr];
   end

   assign data = data_q;

endmodule

// File: rtl/activation_pipe.sv
// Three-stage multi-lane activation unit (sigmoid / tanh / ReLU / bypass) with
// valid/ready on both sides. Tanh reuses the sigmoid table via tanh(x) = 2*sig(2x) - 1.
module activation_pipe
   import activation_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int LANES  = 1,
   parameter int LUT_AW = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_mode,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data
);

   localparam int IDX_LSB = FRAC_W - int'(LUT_STEP_SHIFT);
   localparam logic [DATA_W-1:0] ONE_W = DATA_W'(act_one(FRAC_W));
   localparam logic [DATA_W+1:0] ONE_X = (DATA_W+2)'(act_one(FRAC_W));
   localparam logic [DATA_W:0]   SAT_X = (DATA_W+1)'(act_sat(FRAC_W, LUT_AW));

   logic      adv;
   logic      s1_valid_q, s2_valid_q, s3_valid_q;
   act_mode_e s1_mode_q, s2_mode_q;
   act_mode_e in_mode_e;

   // The whole pipe moves together; it only stops when a result is waiting.
   assign adv       = ~s3_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = s3_valid_q;
   assign in_mode_e = act_mode_e'(in_mode);

   // Stage valid bits and the mode that travels alongside each transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_mode_q  <= ACT_SIGMOID;
         s2_mode_q  <= ACT_SIGMOID;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
         if (in_valid)   s1_mode_q <= in_mode_e;
         if (s1_valid_q) s2_mode_q <= s1_mode_q;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] a;
      logic [DATA_W:0]   b;
      logic              sat_d;
      logic [LUT_AW-1:0] idx_d;
      logic              s1_sat_q, s2_sat_q;
      logic [LUT_AW-1:0] s1_idx_q;
      logic [DATA_W-1:0] s1_x_q, s2_x_q;
      logic [DATA_W-1:0] r;
      logic [DATA_W+1:0] t2;
      logic [DATA_W-1:0] t;
      logic              neg;
      logic [DATA_W-1:0] res_d;
      logic [DATA_W-1:0] out_q;

      // Magnitude, saturation and table index; 0x8000 negates to itself and saturates.
      always_comb begin
         x = in_data[gi*DATA_W +: DATA_W];
         a = x[DATA_W-1] ? -x : x;
         b = {a, 1'b0};
         if (in_mode_e == ACT_TANH) begin
            sat_d = (b >= SAT_X);
            idx_d = b[IDX_LSB +: LUT_AW];
         end else begin
            sat_d = ({1'b0, a} >= SAT_X);
            idx_d = a[IDX_LSB +: LUT_AW];
         end
      end

      // Lane registers for S1 and S2; each loads only when a live transaction enters it.
      always_ff @(posedge clk) begin
         if (rst) begin
            s1_sat_q <= 1'b0;
            s1_idx_q <= '0;
            s1_x_q   <= '0;
            s2_sat_q <= 1'b0;
            s2_x_q   <= '0;
         end else if (adv) begin
            if (in_valid) begin
               s1_sat_q <= sat_d;
               s1_idx_q <= idx_d;
               s1_x_q   <= x;
            end
            if (s1_valid_q) begin
               s2_sat_q <= s1_sat_q;
               s2_x_q   <= s1_x_q;
            end
         end
      end

      sigmoid_lut #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W),
         .LUT_AW (LUT_AW)
      ) u_lut (
         .clk  (clk),
         .en   (adv),
         .addr (s1_idx_q),
         .data (r)
      );

      // Rebuild the signed result from the table value, the sign and the mode.
      always_comb begin
         neg = s2_x_q[DATA_W-1];
         t2  = {1'b0, r, 1'b0} - ONE_X;
         if (s2_sat_q)          t = ONE_W;
         else if (t2[DATA_W+1]) t = '0;
         else if (t2 > ONE_X)   t = ONE_W;
         else                   t = t2[DATA_W-1:0];
         case (s2_mode_q)
            ACT_SIGMOID: begin
               if (s2_sat_q) res_d = neg ? '0 : ONE_W;
               else          res_d = neg ? (ONE_W - r) : r;
            end
            ACT_TANH: res_d = neg ? -t : t;
            ACT_RELU: res_d = neg ? '0 : s2_x_q;
            default:  res_d = s2_x_q;
         endcase
      end

      // Output register; holds while the consumer stalls.
      always_ff @(posedge clk) begin
         if (rst)                    out_q <= '0;
         else if (adv && s2_valid_q) out_q <= res_d;
      end

      assign out_data[gi*DATA_W +: DATA_W] = out_q;
   end

endmodule
